// File: rtl/e_calc_pkg.sv
// Shared types and constants for the e series accumulator and the fixed-to-real stage.
package e_calc_pkg;
  localparam int WORD_W   = 16;
  localparam int INT_BITS = 2;
  // 1.0 in the fixed-point format, as it appears in the most significant word
  localparam logic [WORD_W-1:0] ONE_MSW = WORD_W'(1) << (WORD_W - INT_BITS);

  typedef enum logic [2:0] {IDLE, INIT, DIV, ADD, CHECK, DONE} state_t;
endpackage

// File: rtl/mw_div_step.sv
// Restoring shift-subtract divider: {rem, word} / k, one quotient bit per cycle.
// Done is raised in the final step cycle with the post-step quotient/remainder on the outputs.
module mw_div_step
  import e_calc_pkg::*;
#(
  parameter int KW = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [KW-1:0]     i_rem,
  input  logic [WORD_W-1:0] i_word,
  input  logic [KW-1:0]     i_k,
  output logic              o_done,
  output logic [WORD_W-1:0] o_quot,
  output logic [KW-1:0]     o_rem
);
  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST_STEP = CW'(WORD_W - 1);

  logic [KW-1:0]     r_rem;
  logic [WORD_W-1:0] r_shift;
  logic [KW-1:0]     r_k;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;

  logic [KW:0]       w_trial;
  logic [KW:0]       w_diff;
  logic              w_ge;
  logic [KW-1:0]     w_rem_nxt;
  logic [WORD_W-1:0] w_shift_nxt;

  // remainder stays below k, so KW bits hold it after the restore/subtract
  assign w_trial     = {r_rem, r_shift[WORD_W-1]};
  assign w_diff      = w_trial - {1'b0, r_k};
  assign w_ge        = (w_trial >= {1'b0, r_k});
  assign w_rem_nxt   = w_ge ? w_diff[KW-1:0] : w_trial[KW-1:0];
  assign w_shift_nxt = {r_shift[WORD_W-2:0], w_ge};

  assign o_done = r_busy && (r_cnt == LAST_STEP);
  assign o_quot = w_shift_nxt;
  assign o_rem  = w_rem_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem   <= '0;
      r_shift <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (i_start) begin
      r_rem   <= i_rem;
      r_shift <= i_word;
      r_k     <= i_k;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_rem   <= w_rem_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= r_cnt + 1'b1;
      if (r_cnt == LAST_STEP) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/e_series_accum.sv
// Word-serial computation of e = sum(1/k!) in 2.(WORDS*16-2) fixed point.
// state | meaning
// IDLE  | waiting for start after reset
// INIT  | load term = sum = 1.0, k = 1
// DIV   | term /= k, MSW first, 17 cycles per word
// ADD   | sum += term, LSW first, 1 cycle per word
// CHECK | stop on zero term or k == KMAX, else k++
// DONE  | result valid, waiting for start
module e_series_accum
  import e_calc_pkg::*;
#(
  parameter int  WORDS = 32,
  parameter int  KMAX  = 127,
  localparam int KW    = $clog2(KMAX + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_trunc,
  output logic [KW-1:0]     o_terms,
  output logic [WORD_W-1:0] o_fixed_data [WORDS]
);
  localparam int WIDX_W = $clog2(WORDS);
  localparam logic [WIDX_W-1:0] LAST_W = WIDX_W'(WORDS - 1);
  localparam logic [KW-1:0]     K_MAX  = KW'(KMAX);

  state_t            r_state;
  logic [WORD_W-1:0] r_term [WORDS];
  logic [WORD_W-1:0] r_sum  [WORDS];
  logic [WIDX_W-1:0] r_w;
  logic [KW-1:0]     r_rem;
  logic [KW-1:0]     r_k;
  logic              r_carry;
  logic              r_zero_acc;
  logic              r_issue;
  logic              r_busy;
  logic              r_done;
  logic              r_trunc;
  logic [KW-1:0]     r_terms;

  logic              w_div_start;
  logic              w_div_done;
  logic [WORD_W-1:0] w_quot;
  logic [KW-1:0]     w_drem;
  logic [WORD_W:0]   w_add;

  assign w_div_start = (r_state == DIV) && r_issue;
  assign w_add = {1'b0, r_sum[r_w]} + {1'b0, r_term[r_w]} + {{WORD_W{1'b0}}, r_carry};

  mw_div_step #(.KW(KW)) u_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_div_start),
    .i_rem   (r_rem),
    .i_word  (r_term[r_w]),
    .i_k     (r_k),
    .o_done  (w_div_done),
    .o_quot  (w_quot),
    .o_rem   (w_drem)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_w        <= '0;
      r_rem      <= '0;
      r_k        <= '0;
      r_carry    <= 1'b0;
      r_zero_acc <= 1'b0;
      r_issue    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_trunc    <= 1'b0;
      r_terms    <= '0;
      for (int i = 0; i < WORDS; i++) begin
        r_term[i] <= '0;
        r_sum[i]  <= '0;
      end
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state <= INIT;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        INIT: begin
          for (int i = 0; i < WORDS; i++) begin
            r_term[i] <= '0;
            r_sum[i]  <= '0;
          end
          r_term[0]  <= ONE_MSW;
          r_sum[0]   <= ONE_MSW;
          r_k        <= KW'(1);
          r_rem      <= '0;
          r_zero_acc <= 1'b1;
          r_w        <= '0;
          r_issue    <= 1'b1;
          r_state    <= DIV;
        end
        DIV: begin
          r_issue <= 1'b0;
          if (w_div_done) begin
            r_term[r_w] <= w_quot;
            r_rem       <= w_drem;
            r_zero_acc  <= r_zero_acc & (w_quot == '0);
            // r_w is left on the LSW so the add can run LSW first
            if (r_w == LAST_W) begin
              r_carry <= 1'b0;
              r_state <= ADD;
            end else begin
              r_w     <= r_w + 1'b1;
              r_issue <= 1'b1;
            end
          end
        end
        ADD: begin
          {r_carry, r_sum[r_w]} <= w_add;
          if (r_w == '0) r_state <= CHECK;
          else           r_w     <= r_w - 1'b1;
        end
        CHECK: begin
          if (r_zero_acc || (r_k == K_MAX)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_terms <= r_k;
            r_trunc <= !r_zero_acc;
          end else begin
            r_k        <= r_k + 1'b1;
            r_rem      <= '0;
            r_zero_acc <= 1'b1;
            r_w        <= '0;
            r_issue    <= 1'b1;
            r_state    <= DIV;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_trunc      = r_trunc;
  assign o_terms      = r_terms;
  assign o_fixed_data = r_sum;
endmodule

// File: tb/tb_e_series_accum.sv
// Scoreboard bench for e_series_accum: three instances (2 words/KMAX 127, 2 words/KMAX 5, 32 words).
module tb_e_series_accum;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_b, start_c;
  logic busy_a, done_a, trunc_a;
  logic busy_b, done_b, trunc_b;
  logic busy_c, done_c, trunc_c;
  logic [6:0]  terms_a, terms_c;
  logic [2:0]  terms_b;
  logic [15:0] fd_a [2];
  logic [15:0] fd_b [2];
  logic [15:0] fd_c [32];

  e_series_accum #(.WORDS(2), .KMAX(127)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .o_busy(busy_a), .o_done(done_a),
    .o_trunc(trunc_a), .o_terms(terms_a), .o_fixed_data(fd_a));
  e_series_accum #(.WORDS(2), .KMAX(5)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .o_busy(busy_b), .o_done(done_b),
    .o_trunc(trunc_b), .o_terms(terms_b), .o_fixed_data(fd_b));
  e_series_accum #(.WORDS(32), .KMAX(127)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_c), .o_busy(busy_c), .o_done(done_c),
    .o_trunc(trunc_c), .o_terms(terms_c), .o_fixed_data(fd_c));

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           terms;
    bit           trunc;
    logic [511:0] lo;
    logic [511:0] hi;
    logic [511:0] mask;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  task automatic chk(input string name, input bit ok, input logic [511:0] act, input logic [511:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [511:0] flat_a();
    return {480'd0, fd_a[0], fd_a[1]};
  endfunction
  function automatic logic [511:0] flat_b();
    return {480'd0, fd_b[0], fd_b[1]};
  endfunction
  function automatic logic [511:0] flat_c();
    logic [511:0] r = '0;
    for (int i = 0; i < 32; i++) r = {r[495:0], fd_c[i]};
    return r;
  endfunction

  // golden: term_k = floor(term_{k-1}/k) starting at 1.0 = 2^f
  task automatic model(input int f, input int kmax, output logic [511:0] s,
                       output int nt, output bit tr);
    logic [511:0] term;
    term = 512'd1 << f;
    s  = term;
    nt = 0;
    tr = 1'b0;
    for (int k = 1; k <= kmax; k++) begin
      term = term / 512'(k);
      s    = s + term;
      if (term == '0) begin nt = k; tr = 1'b0; break; end
      if (k == kmax)  begin nt = k; tr = 1'b1; break; end
    end
  endtask

  task automatic compare_result(input string tag, input exp_t e, input int terms,
                                input bit trunc, input logic [511:0] data);
    logic [511:0] d;
    d = data & e.mask;
    chk({tag, "_terms"}, terms == e.terms, 512'(terms), 512'(e.terms));
    chk({tag, "_trunc"}, trunc == e.trunc, 512'(trunc), 512'(e.trunc));
    chk({tag, "_data"}, (d >= e.lo) && (d <= e.hi), d, e.lo);
  endtask

  // monitor: one expected entry consumed per rising edge of done
  bit pd_a = 0, pd_b = 0, pd_c = 0;
  always @(negedge clk) begin
    if (done_a && !pd_a) begin
      if (q_a.size() == 0) chk("a_unexpected_done", 1'b0, 512'd1, 512'd0);
      else compare_result("a", q_a.pop_front(), int'(terms_a), trunc_a, flat_a());
    end
    if (done_b && !pd_b) begin
      if (q_b.size() == 0) chk("b_unexpected_done", 1'b0, 512'd1, 512'd0);
      else compare_result("b", q_b.pop_front(), int'(terms_b), trunc_b, flat_b());
    end
    if (done_c && !pd_c) begin
      if (q_c.size() == 0) chk("c_unexpected_done", 1'b0, 512'd1, 512'd0);
      else compare_result("c", q_c.pop_front(), int'(terms_c), trunc_c, flat_c());
    end
    pd_a = done_a;
    pd_b = done_b;
    pd_c = done_c;
  end

  function automatic logic get_done(input int w);
    case (w)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  // cyc counts rising edges from the one that samples start up to the one that raises done
  task automatic run(input int w, input bit hold, input int budget, output int cyc);
    @(negedge clk);
    set_start(w, 1'b1);
    @(posedge clk); #1;
    if (!hold) set_start(w, 1'b0);
    cyc = 1;
    while (!get_done(w) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_within_budget", get_done(w), 512'(get_done(w)), 512'd1);
  endtask

  localparam logic [511:0] MASK32  = {480'd0, 32'hFFFF_FFFF};
  localparam logic [511:0] E30     = {480'd0, 32'hADF8_5453};
  localparam logic [511:0] E30_LO  = {480'd0, 32'hADF8_544C};
  localparam logic [511:0] E30_HI  = {480'd0, 32'hADF8_5458};
  localparam logic [511:0] E30_K5  = 512'd2916998620;

  initial begin
    int cyc;
    int nt;
    bit tr;
    logic [511:0] gold;
    exp_t e;

    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  busy_a  == 1'b0, 512'(busy_a), 512'd0);
    chk("rst_done",  done_a  == 1'b0, 512'(done_a), 512'd0);
    chk("rst_trunc", trunc_a == 1'b0, 512'(trunc_a), 512'd0);
    chk("rst_terms", terms_a == 7'd0, 512'(terms_a), 512'd0);
    chk("rst_data_a", flat_a() == '0, flat_a(), 512'd0);
    chk("rst_data_c", flat_c() == '0, flat_c(), 512'd0);
    rst_n = 1'b1;

    // e to 30 fraction bits, plus per-term timing
    e = '{terms: 13, trunc: 1'b0, lo: E30, hi: E30, mask: MASK32};
    q_a.push_back(e);
    run(0, 1'b0, 600, cyc);
    chk("a_cycles", cyc == 483, 512'(cyc), 512'd483);
    chk("a_fd0", fd_a[0] == 16'hADF8, 512'(fd_a[0]), 512'h0ADF8);
    chk("a_range", (flat_a() >= E30_LO) && (flat_a() <= E30_HI), flat_a(), E30_LO);

    // truncated series
    e = '{terms: 5, trunc: 1'b1, lo: E30_K5, hi: E30_K5, mask: MASK32};
    q_b.push_back(e);
    run(1, 1'b0, 600, cyc);
    chk("b_cycles", cyc == 2 + 5 * 37, 512'(cyc), 512'(2 + 5 * 37));

    // 32 words, against the long-division model (top 496 bits)
    model(510, 127, gold, nt, tr);
    e = '{terms: nt, trunc: tr, lo: gold & ~512'hFFFF, hi: gold & ~512'hFFFF, mask: ~512'hFFFF};
    q_c.push_back(e);
    run(2, 1'b0, 60000, cyc);
    chk("c_terms_le_100", int'(terms_c) <= 100, 512'(terms_c), 512'd100);
    chk("c_fd0", fd_c[0] == 16'hADF8, 512'(fd_c[0]), 512'h0ADF8);
    chk("c_fd1", fd_c[1] == 16'h5458, 512'(fd_c[1]), 512'h05458);

    // asynchronous reset in the middle of a division
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (38) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", busy_a == 1'b1, 512'(busy_a), 512'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy",  busy_a  == 1'b0, 512'(busy_a), 512'd0);
    chk("arst_done",  done_a  == 1'b0, 512'(done_a), 512'd0);
    chk("arst_trunc", trunc_a == 1'b0, 512'(trunc_a), 512'd0);
    chk("arst_terms", terms_a == 7'd0, 512'(terms_a), 512'd0);
    chk("arst_data",  flat_a() == '0, flat_a(), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    e = '{terms: 13, trunc: 1'b0, lo: E30, hi: E30, mask: MASK32};
    q_a.push_back(e);
    run(0, 1'b0, 600, cyc);
    chk("a_after_rst_cycles", cyc == 483, 512'(cyc), 512'd483);

    // start held high: one run, done for one cycle, restart, identical second result
    q_a.push_back(e);
    q_a.push_back(e);
    run(0, 1'b1, 600, cyc);
    chk("hold_cycles", cyc == 483, 512'(cyc), 512'd483);
    @(posedge clk); #1;
    chk("hold_done_drop", done_a == 1'b0, 512'(done_a), 512'd0);
    chk("hold_restart_busy", busy_a == 1'b1, 512'(busy_a), 512'd1);
    start_a = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 600) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("hold_second_done", done_a == 1'b1, 512'(done_a), 512'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_stays", done_a == 1'b1, 512'(done_a), 512'd1);

    repeat (2) @(negedge clk);
    chk("q_a_empty", q_a.size() == 0, 512'(q_a.size()), 512'd0);
    chk("q_b_empty", q_b.size() == 0, 512'(q_b.size()), 512'd0);
    chk("q_c_empty", q_c.size() == 0, 512'(q_c.size()), 512'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
